// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader: FSM state
// encoding and the width helper for the chain bit counter.
package ccff_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } ccff_state_e;

   // Width of a counter that must hold values 0..chain_len inclusive.
   function automatic int ccff_cnt_w(input int chain_len);
      return $clog2(chain_len + 1);
   endfunction

endpackage

// File: rtl/ccff_shadow_chk.sv
// Shadow copy of the downstream configuration chain plus readback checker.
// The shadow shifts in lock-step with the real chain, so whatever falls out
// of the chain tail must equal the shadow's last bit on every shift cycle.
module ccff_shadow_chk #(
   parameter int CHAIN_LEN = 32
) (
   input  logic prog_clk,
   input  logic pReset,
   input  logic shift_en,
   input  logic head,
   input  logic tail,
   input  logic clr_err,
   output logic error
);

   logic [CHAIN_LEN-1:0] shadow_q;
   logic [CHAIN_LEN-1:0] shadow_d;
   logic                 error_q;
   logic                 error_d;

   // Next shadow contents: head enters bit 0, every other bit moves up one.
   assign shadow_d[0] = head;
   generate
      for (genvar gi = 1; gi < CHAIN_LEN; gi++) begin : g_shadow
         assign shadow_d[gi] = shadow_q[gi-1];
      end
   endgenerate

   // Shadow register; resets to zero like the real chain and is never
   // cleared by start, so a later load verifies the earlier contents.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         shadow_q <= '0;
      end else if (shift_en) begin
         shadow_q <= shadow_d;
      end
   end

   // Sticky mismatch flag: set on any tail/shadow disagreement while
   // shifting, cleared only by an accepted start.
   always_comb begin
      error_d = error_q;
      if (clr_err) begin
         error_d = 1'b0;
      end else if (shift_en && (tail != shadow_q[CHAIN_LEN-1])) begin
         error_d = 1'b1;
      end
   end

   // Error flag register.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign error = error_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words LSB-first into a serial configuration chain,
// stalling cleanly on input underrun, and verifies the chain's previous
// contents as they emerge from its tail.
module ccff_chain_loader
   import ccff_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CHAIN_LEN = 32
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [DATA_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int CNT_W = ccff_cnt_w(CHAIN_LEN);
   localparam int WB_W  = $clog2(DATA_W + 1);

   ccff_state_e       state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WB_W-1:0]   wbit_q, wbit_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic              head_q, head_d;
   logic              shift_en_q, shift_en_d;
   logic              err_clr;

   // Next-state logic. The serial outputs are registered from the next
   // state so that ccff_head equals buf_q[0] in exactly the SHIFT cycles.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      wbit_d     = wbit_q;
      buf_d      = buf_q;
      err_clr    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_FETCH;
               bit_cnt_d = '0;
               err_clr   = 1'b1;
            end
         end
         ST_FETCH: begin
            if (word_valid) begin
               buf_d   = word_data;
               wbit_d  = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            buf_d     = buf_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            wbit_d    = wbit_q + 1'b1;
            // Chain full wins over word exhaustion: leftover bits of a
            // partial last word are simply dropped.
            if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
               state_d = ST_DONE;
            end else if (wbit_d == WB_W'(DATA_W)) begin
               state_d = ST_FETCH;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      shift_en_d = (state_d == ST_SHIFT);
      head_d     = shift_en_d ? buf_d[0] : head_q;
   end

   // Control and datapath registers.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         wbit_q     <= '0;
         buf_q      <= '0;
         head_q     <= 1'b0;
         shift_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         wbit_q     <= wbit_d;
         buf_q      <= buf_d;
         head_q     <= head_d;
         shift_en_q <= shift_en_d;
      end
   end

   assign word_ready    = (state_q == ST_FETCH);
   assign busy          = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
   assign done          = (state_q == ST_DONE);
   assign ccff_head     = head_q;
   assign ccff_shift_en = shift_en_q;

   ccff_shadow_chk #(
      .CHAIN_LEN(CHAIN_LEN)
   ) u_shadow (
      .prog_clk(prog_clk),
      .pReset  (pReset),
      .shift_en(shift_en_q),
      .head    (head_q),
      .tail    (ccff_tail),
      .clr_err (err_clr),
      .error   (error)
   );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 32-bit chain instance driven from a vector
// table, directed corner sequences and random loads, plus a 12-bit chain
// instance for the partial-last-word case. Each DUT drives a behavioural
// chain model whose tail feeds back into the DUT.
module tb_ccff_chain_loader;

   logic       clk;
   logic       pReset;
   logic       start;
   logic [7:0] word_data;
   logic       word_valid;
   logic       word_ready, ccff_head, ccff_shift_en, busy, done, error;
   logic       ccff_tail;
   logic       inject;

   logic       start12;
   logic [7:0] wd12;
   logic       wv12;
   logic       ready12, head12, shen12, busy12, done12, error12, tail12;

   logic [31:0] chain32;
   logic [11:0] chain12;

   int errors = 0;
   int checks = 0;

   ccff_chain_loader #(.DATA_W(8), .CHAIN_LEN(32)) dut32 (
      .prog_clk(clk), .pReset(pReset), .start(start),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
      .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
      .busy(busy), .done(done), .error(error)
   );

   ccff_chain_loader #(.DATA_W(8), .CHAIN_LEN(12)) dut12 (
      .prog_clk(clk), .pReset(pReset), .start(start12),
      .word_data(wd12), .word_valid(wv12), .word_ready(ready12),
      .ccff_head(head12), .ccff_shift_en(shen12), .ccff_tail(tail12),
      .busy(busy12), .done(done12), .error(error12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream chain models, reset by the same pReset as the loader.
   always @(posedge clk or posedge pReset) begin
      if (pReset) chain32 <= '0;
      else if (ccff_shift_en) chain32 <= {chain32[30:0], ccff_head};
   end
   always @(posedge clk or posedge pReset) begin
      if (pReset) chain12 <= '0;
      else if (shen12) chain12 <= {chain12[10:0], head12};
   end
   assign ccff_tail = chain32[31] ^ inject;
   assign tail12    = chain12[11];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One load on the 32-bit instance. Words go LSB byte first; word index
   // stall_word is withheld for stall_len FETCH cycles; the tail is inverted
   // during shift number fault_shift; pReset is raised during shift rst_shift.
   task automatic run_load(input logic [31:0] words, input int stall_word, input int stall_len,
                           input int fault_shift, input int rst_shift,
                           output int cycles, output logic [31:0] head_s, output logic [31:0] tail_s,
                           output int nshift, output int first_err, output int done_cnt);
      int idx;
      int stall_left;
      cycles = -1; nshift = 0; first_err = -1; done_cnt = 0;
      head_s = '0; tail_s = '0; idx = 0; stall_left = stall_len;
      @(negedge clk);
      start = 1'b1; word_valid = 1'b1; word_data = words[7:0];
      @(posedge clk);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (error && first_err < 0) first_err = nshift;
         if (done) begin
            done_cnt++;
            cycles = c;
            break;
         end
         if (ccff_shift_en) begin
            if (nshift < 32) begin
               head_s[nshift] = ccff_head;
               tail_s[nshift] = chain32[31];
            end
            nshift++;
            inject = (nshift == fault_shift);
            if (nshift == rst_shift) begin
               pReset = 1'b1;
               inject = 1'b0;
               #1;
               break;
            end
         end else begin
            inject = 1'b0;
         end
         if (word_ready && idx == stall_word && stall_left > 0) begin
            word_valid = 1'b0;
            stall_left--;
         end else begin
            word_valid = 1'b1;
            word_data  = (idx < 4) ? words[idx*8 +: 8] : 8'h00;
            if (word_ready) idx++;
         end
         @(posedge clk);
      end
      word_valid = 1'b0;
      inject = 1'b0;
   endtask

   typedef struct {
      logic [31:0] words;
      int          stall_word;
      int          stall_len;
      int          fault_shift;
      logic [31:0] exp_head;
      logic [31:0] exp_tail;
      int          exp_cycles;
      logic        exp_err;
      int          exp_first_err;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int          cyc, ns, fe, dc;
      logic [31:0] hs, ts, prev, w;
      int          sw, sl;

      vecs[0] = '{32'h01FF3CA5, -1, 0, -1, 32'h01FF3CA5, 32'h00000000, 36, 1'b0, -1};
      vecs[1] = '{32'h00000000, -1, 0, -1, 32'h00000000, 32'h01FF3CA5, 36, 1'b0, -1};
      vecs[2] = '{32'h5A5A5A5A, -1, 0,  5, 32'h5A5A5A5A, 32'h00000000, 36, 1'b1,  5};
      vecs[3] = '{32'h01FF3CA5,  2, 3, -1, 32'h01FF3CA5, 32'h5A5A5A5A, 39, 1'b0, -1};

      pReset = 1'b1; start = 1'b0; word_data = '0; word_valid = 1'b0; inject = 1'b0;
      start12 = 1'b0; wd12 = '0; wv12 = 1'b0;
      #1;
      check("reset_outputs", {word_ready, ccff_head, ccff_shift_en, busy, done, error}, 6'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      pReset = 1'b0;
      check("reset_outputs_after_release", {word_ready, ccff_head, ccff_shift_en, busy, done, error}, 6'b0);

      // Table-driven loads.
      for (int v = 0; v < 4; v++) begin
         run_load(vecs[v].words, vecs[v].stall_word, vecs[v].stall_len, vecs[v].fault_shift, -1,
                  cyc, hs, ts, ns, fe, dc);
         $display("vec %0d: words=%08h cycles=%0d shifts=%0d head=%08h tail=%08h err=%0b",
                  v, vecs[v].words, cyc, ns, hs, ts, error);
         check($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cycles);
         check($sformatf("vec%0d_shifts", v), ns, 32);
         check($sformatf("vec%0d_head", v), hs, vecs[v].exp_head);
         check($sformatf("vec%0d_tail", v), ts, vecs[v].exp_tail);
         check($sformatf("vec%0d_error", v), error, vecs[v].exp_err);
         check($sformatf("vec%0d_first_err", v), fe, vecs[v].exp_first_err);
         check($sformatf("vec%0d_busy_at_done", v), busy, 1'b0);
         if (v == 1) check("shadow_zero_after_zero_load", dut32.u_shadow.shadow_q, 32'h0);
      end
      @(negedge clk);
      check("done_single_cycle", {done, busy}, 2'b00);

      // Reset in the middle of a load.
      run_load(32'hDEADBEEF, -1, 0, -1, 17, cyc, hs, ts, ns, fe, dc);
      $display("abort: shifts=%0d outputs=%06b", ns,
               {word_ready, ccff_head, ccff_shift_en, busy, done, error});
      check("abort_shift_count", ns, 17);
      check("abort_outputs_zero", {word_ready, ccff_head, ccff_shift_en, busy, done, error}, 6'b0);
      check("abort_shadow_zero", dut32.u_shadow.shadow_q, 32'h0);
      repeat (2) @(negedge clk);
      pReset = 1'b0;
      dc = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done || busy) dc++;
      end
      check("abort_no_done", dc, 0);
      run_load(32'h1234C3C3, -1, 0, -1, -1, cyc, hs, ts, ns, fe, dc);
      $display("fresh: cycles=%0d head=%08h tail=%08h err=%0b", cyc, hs, ts, error);
      check("fresh_cycles", cyc, 36);
      check("fresh_head", hs, 32'h1234C3C3);
      check("fresh_tail", ts, 32'h0);
      check("fresh_error", error, 1'b0);
      prev = 32'h1234C3C3;

      // Random loads against a stream-level model: the head stream is the
      // words' bits LSB first, the tail replays the previous load, and the
      // latency is chain length + one fetch per word + any stall cycles.
      for (int r = 0; r < 12; r++) begin
         w  = $urandom;
         sw = $urandom_range(0, 4);
         sl = $urandom_range(0, 4);
         run_load(w, sw, sl, -1, -1, cyc, hs, ts, ns, fe, dc);
         $display("rand %0d: words=%08h stall=%0d/%0d cycles=%0d head=%08h tail=%08h err=%0b",
                  r, w, sw, sl, cyc, hs, ts, error);
         check("rand_cycles", cyc, 32 + 4 + ((sw < 4) ? sl : 0));
         check("rand_head", hs, w);
         check("rand_tail", ts, prev);
         check("rand_error", error, 1'b0);
         prev = w;
      end

      // 12-bit chain: second word's upper nibble must be dropped.
      begin
         int          n12, idx12, hs12, cyc12;
         logic [11:0] s12;
         logic [7:0]  wl [2];
         wl[0] = 8'hFF; wl[1] = 8'h0F;
         n12 = 0; idx12 = 0; hs12 = 0; cyc12 = -1; s12 = '0;
         @(negedge clk);
         start12 = 1'b1; wv12 = 1'b1; wd12 = wl[0];
         @(posedge clk);
         for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start12 = 1'b0;
            if (done12) begin
               cyc12 = c;
               break;
            end
            if (shen12) begin
               if (n12 < 12) s12[n12] = head12;
               n12++;
            end
            wd12 = (idx12 < 2) ? wl[idx12] : 8'h00;
            if (ready12) begin
               idx12++;
               hs12++;
            end
            @(posedge clk);
         end
         wv12 = 1'b0;
         $display("chain12: cycles=%0d shifts=%0d stream=%03h words_taken=%0d err=%0b",
                  cyc12, n12, s12, hs12, error12);
         check("c12_cycles", cyc12, 14);
         check("c12_shifts", n12, 12);
         check("c12_stream", s12, 12'hFFF);
         check("c12_words_taken", hs12, 2);
         check("c12_error", error12, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
